pipe_regs: RTL and testbench

- Parametrised multi-stage pipeline register chain for the MIPS core, generalising the single IF/ID latch.
- Carries instruction word, PC+4, exception code, delay-slot flag and valid bit through DEPTH stages.
- Per-stage stall and flush, plus a global interrupt flush.
- Instantiated as IF/ID (DEPTH=1) or as fused multi-stage delay chains; bubbles are explicit (valid=0) instead of zeroed instructions only.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage.sv | 60 ++++++
 rtl/pipe_regs.sv | 122 ++++++++++++
 tb/tb_pipe_regs.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_regs register chain.
// The stage record uses the default field widths of the chain.
package pipe_pkg;

  localparam int IRW_DEF  = 32;
  localparam int PCW_DEF  = 32;
  localparam int EXCW_DEF = 5;

  localparam logic [EXCW_DEF-1:0] EXC_NONE = 5'd0;

  typedef struct packed {
    logic [IRW_DEF-1:0]  ir;
    logic [PCW_DEF-1:0]  pc4;
    logic [EXCW_DEF-1:0] exc;
    logic                bd;
    logic                valid;
  } pipe_rec_t;

  localparam pipe_rec_t PIPE_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the pipe_regs chain.
// Priority: flush (bubble) > advance > hold. An advancing stage whose
// upstream is holding takes a bubble rather than a copy of upstream.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int IRW           = IRW_DEF,
  parameter int PCW           = PCW_DEF,
  parameter int EXCW          = EXCW_DEF,
  parameter bit FLUSH_KEEP_PC = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            up_en,
  input  logic            flush,
  input  logic [IRW-1:0]  src_ir,
  input  logic [PCW-1:0]  src_pc4,
  input  logic [EXCW-1:0] src_exc,
  input  logic            src_bd,
  input  logic            src_valid,
  output logic [IRW-1:0]  q_ir,
  output logic [PCW-1:0]  q_pc4,
  output logic [EXCW-1:0] q_exc,
  output logic            q_bd,
  output logic            q_valid
);

  // Stage register: flush, then advance (source or bubble), else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ir    <= '0;
      q_pc4   <= '0;
      q_exc   <= '0;
      q_bd    <= 1'b0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_ir    <= '0;
      q_pc4   <= FLUSH_KEEP_PC ? src_pc4 : '0;
      q_exc   <= EXCW'(EXC_NONE);
      q_bd    <= 1'b0;
      q_valid <= 1'b0;
    end else if (en) begin
      if (up_en) begin
        q_ir    <= src_ir;
        q_pc4   <= src_pc4;
        q_exc   <= src_exc;
        q_bd    <= src_bd;
        q_valid <= src_valid;
      end else begin
        q_ir    <= '0;
        q_pc4   <= '0;
        q_exc   <= EXCW'(EXC_NONE);
        q_bd    <= 1'b0;
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_regs.sv
// Multi-stage pipeline register chain (IF/ID when DEPTH=1).
// Optional perf counters are built when PIPE_REGS_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_regs
  import pipe_pkg::*;
#(
  parameter int DEPTH         = 1,
  parameter int IRW           = IRW_DEF,
  parameter int PCW           = PCW_DEF,
  parameter int EXCW          = EXCW_DEF,
  parameter bit FLUSH_KEEP_PC = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] en,
  input  logic [DEPTH-1:0] clr,
  input  logic             hwint,
  input  logic [IRW-1:0]   in_ir,
  input  logic [PCW-1:0]   in_pc4,
  input  logic [EXCW-1:0]  in_exc,
  input  logic             in_bd,
  input  logic             in_valid,
  output logic [IRW-1:0]   out_ir,
  output logic [PCW-1:0]   out_pc4,
  output logic [EXCW-1:0]  out_exc,
  output logic             out_bd,
  output logic             out_valid,
  output logic [DEPTH-1:0] stage_valid,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);

  // Element 0 is the chain input, element i+1 is the output of stage i.
  logic [IRW-1:0]  ir_c    [DEPTH+1];
  logic [PCW-1:0]  pc4_c   [DEPTH+1];
  logic [EXCW-1:0] exc_c   [DEPTH+1];
  logic [DEPTH:0]  bd_c;
  logic [DEPTH:0]  valid_c;

  assign ir_c[0]    = in_ir;
  assign pc4_c[0]   = in_pc4;
  assign exc_c[0]   = in_exc;
  assign bd_c[0]    = in_bd;
  assign valid_c[0] = in_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic up_en;
    if (i == 0) begin : g_head
      assign up_en = 1'b1;
    end else begin : g_body
      assign up_en = en[i-1];
    end

    pipe_stage #(
      .IRW           (IRW),
      .PCW           (PCW),
      .EXCW          (EXCW),
      .FLUSH_KEEP_PC (FLUSH_KEEP_PC)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[i]),
      .up_en     (up_en),
      .flush     (hwint | clr[i]),
      .src_ir    (ir_c[i]),
      .src_pc4   (pc4_c[i]),
      .src_exc   (exc_c[i]),
      .src_bd    (bd_c[i]),
      .src_valid (valid_c[i]),
      .q_ir      (ir_c[i+1]),
      .q_pc4     (pc4_c[i+1]),
      .q_exc     (exc_c[i+1]),
      .q_bd      (bd_c[i+1]),
      .q_valid   (valid_c[i+1])
    );

    assign stage_valid[i] = valid_c[i+1];
  end

  assign out_ir    = ir_c[DEPTH];
  assign out_pc4   = pc4_c[DEPTH];
  assign out_exc   = exc_c[DEPTH];
  assign out_bd    = bd_c[DEPTH];
  assign out_valid = valid_c[DEPTH];

`ifdef PIPE_REGS_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_ev;
  logic        flush_ev;

  assign stall_ev = |(~en & stage_valid);
  assign flush_ev = hwint | (|clr);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_ev && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

`ifndef SYNTHESIS
  // A stage advancing into a holding, valid downstream stage drops data.
  for (genvar i = 0; i < DEPTH-1; i++) begin : g_stall_chk
    a_stall_legal: assert property (@(posedge clk) disable iff (!rst_n)
      !(en[i] && !en[i+1] && stage_valid[i+1]))
      else $error("pipe_regs: stage %0d advanced into held valid stage %0d", i, i+1);
  end
`endif

endmodule

// File: tb/tb_pipe_regs.sv
// Testbench for pipe_regs: two instances (DEPTH=3 clearing PC on flush,
// DEPTH=1 keeping PC on flush) against a behavioural reference model.
module tb_pipe_regs;
  import pipe_pkg::*;

  localparam int DA = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [DA-1:0] en_a, clr_a;
  logic [DB-1:0] en_b, clr_b;
  logic hwint;
  logic [31:0] in_ir, in_pc4;
  logic [4:0]  in_exc;
  logic        in_bd, in_valid;

  logic [31:0] a_out_ir, a_out_pc4, a_stall_cnt, a_flush_cnt;
  logic [4:0]  a_out_exc;
  logic        a_out_bd, a_out_valid;
  logic [DA-1:0] a_stage_valid;
  logic [31:0] b_out_ir, b_out_pc4, b_stall_cnt, b_flush_cnt;
  logic [4:0]  b_out_exc;
  logic        b_out_bd, b_out_valid;
  logic [DB-1:0] b_stage_valid;

  always #5 clk = ~clk;

  pipe_regs #(.DEPTH(DA), .FLUSH_KEEP_PC(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .clr(clr_a), .hwint(hwint),
    .in_ir(in_ir), .in_pc4(in_pc4), .in_exc(in_exc), .in_bd(in_bd), .in_valid(in_valid),
    .out_ir(a_out_ir), .out_pc4(a_out_pc4), .out_exc(a_out_exc), .out_bd(a_out_bd),
    .out_valid(a_out_valid), .stage_valid(a_stage_valid),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_regs #(.DEPTH(DB), .FLUSH_KEEP_PC(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr_b), .hwint(hwint),
    .in_ir(in_ir), .in_pc4(in_pc4), .in_exc(in_exc), .in_bd(in_bd), .in_valid(in_valid),
    .out_ir(b_out_ir), .out_pc4(b_out_pc4), .out_exc(b_out_exc), .out_bd(b_out_bd),
    .out_valid(b_out_valid), .stage_valid(b_stage_valid),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Reference model: per instance, an array of stage records plus counters.
  pipe_rec_t   m [2][8];
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) m[w][i] = PIPE_BUBBLE;
      m_stall[w] = '0;
      m_flush[w] = '0;
    end
  endtask

  task automatic model_step(input int w, input int depth, input bit keep,
                            input logic [7:0] e, input logic [7:0] c);
    pipe_rec_t src_in, src;
    pipe_rec_t nxt [8];
    bit any_stall;
    bit up;
    src_in = '{ir: in_ir, pc4: in_pc4, exc: in_exc, bd: in_bd, valid: in_valid};
    any_stall = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (i == 0) begin
        src = src_in;
        up  = 1'b1;
      end else begin
        src = m[w][i-1];
        up  = e[i-1];
      end
      if (!e[i] && m[w][i].valid) any_stall = 1'b1;
      if (hwint || c[i]) begin
        nxt[i] = PIPE_BUBBLE;
        if (keep) nxt[i].pc4 = src.pc4;
      end else if (e[i]) begin
        nxt[i] = up ? src : PIPE_BUBBLE;
      end else begin
        nxt[i] = m[w][i];
      end
    end
    if (any_stall && m_stall[w] != 32'hFFFF_FFFF) m_stall[w] = m_stall[w] + 1;
    if ((hwint || c != 8'd0) && m_flush[w] != 32'hFFFF_FFFF) m_flush[w] = m_flush[w] + 1;
    for (int i = 0; i < depth; i++) m[w][i] = nxt[i];
  endtask

  task automatic check_all();
    logic [DA-1:0] sva;
    logic [31:0] es_a, ef_a, es_b, ef_b;
    for (int i = 0; i < DA; i++) sva[i] = m[0][i].valid;
`ifdef PIPE_REGS_PERF_EN
    es_a = m_stall[0]; ef_a = m_flush[0];
    es_b = m_stall[1]; ef_b = m_flush[1];
`else
    es_a = 32'd0; ef_a = 32'd0; es_b = 32'd0; ef_b = 32'd0;
`endif
    chk("a_ir",    a_out_ir,      m[0][DA-1].ir);
    chk("a_pc4",   a_out_pc4,     m[0][DA-1].pc4);
    chk("a_exc",   a_out_exc,     m[0][DA-1].exc);
    chk("a_bd",    a_out_bd,      m[0][DA-1].bd);
    chk("a_valid", a_out_valid,   m[0][DA-1].valid);
    chk("a_svld",  a_stage_valid, sva);
    chk("a_stall", a_stall_cnt,   es_a);
    chk("a_flush", a_flush_cnt,   ef_a);
    chk("b_ir",    b_out_ir,      m[1][0].ir);
    chk("b_pc4",   b_out_pc4,     m[1][0].pc4);
    chk("b_exc",   b_out_exc,     m[1][0].exc);
    chk("b_bd",    b_out_bd,      m[1][0].bd);
    chk("b_valid", b_out_valid,   m[1][0].valid);
    chk("b_svld",  b_stage_valid, m[1][0].valid);
    chk("b_stall", b_stall_cnt,   es_b);
    chk("b_flush", b_flush_cnt,   ef_b);
  endtask

  // One clock: update the model from pre-edge inputs, then compare mid-cycle.
  task automatic step();
    @(posedge clk);
    model_step(0, DA, 1'b0, 8'(en_a), 8'(clr_a));
    model_step(1, DB, 1'b1, 8'(en_b), 8'(clr_b));
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_inputs();
    in_ir    = $urandom;
    in_pc4   = $urandom;
    in_exc   = 5'($urandom);
    in_bd    = 1'($urandom);
    in_valid = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < DA; i++) begin
      en_a[i]  = ($urandom_range(0, 3) != 0);
      clr_a[i] = ($urandom_range(0, 11) == 0);
    end
    // Never advance into a holding stage that still carries valid data.
    for (int i = DA-2; i >= 0; i--)
      if (en_a[i] && !en_a[i+1] && m[0][i+1].valid) en_a[i] = 1'b0;
    en_b[0]  = ($urandom_range(0, 3) != 0);
    clr_b[0] = ($urandom_range(0, 11) == 0);
    hwint    = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    en_a = '0; clr_a = '0; en_b = '0; clr_b = '0; hwint = 1'b0;
    in_ir = '0; in_pc4 = '0; in_exc = '0; in_bd = 1'b0; in_valid = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Flow latency on the 3-deep chain.
    en_a = '1; en_b = '1;
    in_ir = 32'h2408_0005; in_pc4 = 32'h0000_3004; in_valid = 1'b1;
    step();
    in_ir = '0; in_pc4 = '0; in_valid = 1'b0;
    step();
    chk("flow_early_valid", a_out_valid, 1'b0);
    step();
    chk("flow_ir",    a_out_ir,    32'h2408_0005);
    chk("flow_pc4",   a_out_pc4,   32'h0000_3004);
    chk("flow_valid", a_out_valid, 1'b1);

    // Stall holds, then a stalled upstream feeds a bubble.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_ir = 32'h1000_0000 + k;
      step();
    end
    en_a = '0;
    step();
    step();
    chk("stall_hold_ir",    a_out_ir,    32'h1000_0000);
    chk("stall_hold_valid", a_out_valid, 1'b1);
    en_a = 3'b100;
    step();
    chk("stall_bubble_valid", a_out_valid, 1'b0);
    chk("stall_bubble_ir",    a_out_ir,    32'h0);

    // Flush beats hold; PC kept on the DEPTH=1 instance.
    en_a = '0; en_b = '0; clr_b = 1'b1;
    in_ir = 32'h8C09_0000; in_pc4 = 32'h0000_3010;
    step();
    chk("flush_ir",      b_out_ir,    32'h0);
    chk("flush_valid",   b_out_valid, 1'b0);
    chk("flush_keep_pc", b_out_pc4,   32'h0000_3010);
    clr_b = '0; en_b = '1;

    // Interrupt empties the whole chain.
    en_a = '1; in_valid = 1'b1;
    repeat (3) step();
    chk("irq_pre_full", a_stage_valid, 3'b111);
    hwint = 1'b1;
    step();
    hwint = 1'b0;
    chk("irq_a_empty", a_stage_valid, 3'b000);
    chk("irq_b_empty", b_stage_valid, 1'b0);

    // Asynchronous reset in mid-cycle with the chain full.
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_svld", a_stage_valid, 3'b000);
    chk("rst_async_ir",   a_out_ir,      32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Perf: 5 stall cycles and 2 flush cycles on instance A.
    en_a = '1; en_b = '1; in_valid = 1'b1;
    repeat (3) step();
    en_a = '0;
    repeat (5) step();
    en_a = '1; clr_a = 3'b001;
    repeat (2) step();
    clr_a = '0;
`ifdef PIPE_REGS_PERF_EN
    chk("perf_stall", a_stall_cnt, 32'd5);
    chk("perf_flush", a_flush_cnt, 32'd2);
    force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut_a.stall_cnt_q;
    m_stall[0] = 32'hFFFF_FFFF;
    en_a = '0;
    step();
    chk("perf_sat", a_stall_cnt, 32'hFFFF_FFFF);
    en_a = '1;
`else
    chk("perf_off_stall", a_stall_cnt, 32'd0);
    chk("perf_off_flush", a_flush_cnt, 32'd0);
`endif

    // Randomized traffic against the model.
    repeat (400) begin
      rand_inputs();
      step();
    end
    hwint = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
